// File: rtl/wire_use_unit_if.sv
// Bundle of operand, clear and result signals for wire_use_unit.
// master drives the operands and clear; slave is the wire_use_unit side.
interface wire_use_if #(
  parameter int CNT_W = 8
);
  logic             A_i;
  logic             B_i;
  logic             D_i;
  logic             clr_i;
  logic             E_o;
  logic             E_q_o;
  logic             E_rise_o;
  logic [CNT_W-1:0] E_cnt_o;

  modport master (
    output A_i, B_i, D_i, clr_i,
    input  E_o, E_q_o, E_rise_o, E_cnt_o
  );

  modport slave (
    input  A_i, B_i, D_i, clr_i,
    output E_o, E_q_o, E_rise_o, E_cnt_o
  );
endinterface

// File: rtl/wire_use_unit.sv
// E = (A & B) | D through net C, plus registered copy, rise pulse and saturating
// high-cycle counter. Define WIRE_USE_CNT_EN to build the counter and clear logic.
module wire_use (
  input  logic A_i,
  input  logic B_i,
  input  logic D_i,
  output logic E_o
);
  logic C;

  assign C   = A_i & B_i;
  assign E_o = C | D_i;
endmodule

module wire_use_unit #(
  parameter int CNT_W = 8
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  wire_use_if.slave bus
);
  logic e_comb;
  logic e_q_reg;
  logic e_rise_reg;

  wire_use u_core (
    .A_i (bus.A_i),
    .B_i (bus.B_i),
    .D_i (bus.D_i),
    .E_o (e_comb)
  );

  // E_o stays purely combinational so it is valid during reset and without a clock.
  assign bus.E_o      = e_comb;
  assign bus.E_q_o    = e_q_reg;
  assign bus.E_rise_o = e_rise_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      e_q_reg    <= 1'b0;
      e_rise_reg <= 1'b0;
    end else begin
      e_q_reg    <= e_comb;
      e_rise_reg <= e_comb & ~e_q_reg;
    end
  end

`ifdef WIRE_USE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_reg;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_reg <= '0;
    end else if (bus.clr_i) begin
      cnt_reg <= '0;
    end else if (e_comb && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.E_cnt_o = cnt_reg;
`else
  logic unused_clr;

  assign unused_clr  = bus.clr_i;
  assign bus.E_cnt_o = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_wire_use_unit.sv
// Bench for wire_use_unit: truth-table sweep plus scoreboarded register/counter sequences
// on an 8-bit and a 2-bit counter instance sharing the same stimulus.
module tb_wire_use_unit;
  logic clk;
  logic rst_n;
  logic a, b, d, clr;

  int tests;
  int fails;

  wire_use_if #(.CNT_W(8)) bus8 ();
  wire_use_if #(.CNT_W(2)) bus2 ();

  assign bus8.A_i   = a;
  assign bus8.B_i   = b;
  assign bus8.D_i   = d;
  assign bus8.clr_i = clr;
  assign bus2.A_i   = a;
  assign bus2.B_i   = b;
  assign bus2.D_i   = d;
  assign bus2.clr_i = clr;

  wire_use_unit #(.CNT_W(8)) dut8 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus8)
  );

  wire_use_unit #(.CNT_W(2)) dut2 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic d;
    logic e;
  } tt_vec_t;

  typedef struct {
    logic       e_q;
    logic       e_rise;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
  } exp_t;

  tt_vec_t tt[7];
  exp_t    sb[$];

  // Reference state of the registered outputs.
  logic       m_eq;
  logic       m_rise;
  logic [7:0] m_cnt8;
  logic [1:0] m_cnt2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_eq   = 1'b0;
    m_rise = 1'b0;
    m_cnt8 = 8'd0;
    m_cnt2 = 2'd0;
  endtask

  task automatic step(input logic ai, input logic bi, input logic di, input logic ci);
    logic e;
    exp_t x;
    exp_t y;
    @(negedge clk);
    a   = ai;
    b   = bi;
    d   = di;
    clr = ci;
    e   = (ai & bi) | di;
    m_rise = e & ~m_eq;
    m_eq   = e;
`ifdef WIRE_USE_CNT_EN
    if (ci)                 m_cnt8 = 8'd0;
    else if (e && m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
    if (ci)                 m_cnt2 = 2'd0;
    else if (e && m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
`endif
    x.e_q    = m_eq;
    x.e_rise = m_rise;
    x.cnt8   = m_cnt8;
    x.cnt2   = m_cnt2;
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk("e_q",    32'(bus8.E_q_o),    32'(y.e_q));
    chk("e_rise", 32'(bus8.E_rise_o), 32'(y.e_rise));
    chk("cnt8",   32'(bus8.E_cnt_o),  32'(y.cnt8));
    chk("cnt2",   32'(bus2.E_cnt_o),  32'(y.cnt2));
    chk("e_q_w2", 32'(bus2.E_q_o),    32'(y.e_q));
    $display("[TB] step abd=%b%b%b clr=%b -> E_q=%b rise=%b cnt8=%0d cnt2=%0d",
             ai, bi, di, ci, bus8.E_q_o, bus8.E_rise_o, bus8.E_cnt_o, bus2.E_cnt_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_on;
`ifdef WIRE_USE_CNT_EN
    cnt_on = 1;
`else
    cnt_on = 0;
`endif
    tests = 0;
    fails = 0;
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tt[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tt[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tt[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tt[5] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tt[6] = '{1'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; d = 1'b0; clr = 1'b0;
    model_reset();
    #2;
    chk("rst_e_q",    32'(bus8.E_q_o),    32'd0);
    chk("rst_e_rise", 32'(bus8.E_rise_o), 32'd0);
    chk("rst_cnt8",   32'(bus8.E_cnt_o),  32'd0);

    // Truth table while reset is held: E_o must not depend on clock or reset.
    for (int i = 0; i < 7; i++) begin
      a = tt[i].a; b = tt[i].b; d = tt[i].d;
      #5;
      chk("tt_e8", 32'(bus8.E_o), 32'(tt[i].e));
      chk("tt_e2", 32'(bus2.E_o), 32'(tt[i].e));
      $display("[TB] tt abd=%b%b%b -> E=%b", tt[i].a, tt[i].b, tt[i].d, bus8.E_o);
    end

    a = 1'b0; b = 1'b0; d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Register path: 110 for three clocks.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("regpath_cnt3", 32'(bus8.E_cnt_o), 32'(cnt_on ? 3 : 0));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_cnt5", 32'(bus8.E_cnt_o), 32'(cnt_on ? 5 : 0));

    // Asynchronous reset between edges with E_q high.
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_e_q",    32'(bus8.E_q_o),    32'd0);
    chk("midrst_e_rise", 32'(bus8.E_rise_o), 32'd0);
    chk("midrst_cnt8",   32'(bus8.E_cnt_o),  32'd0);
    chk("midrst_cnt2",   32'(bus2.E_cnt_o),  32'd0);
    chk("midrst_e_on",   32'(bus8.E_o),      32'd1);
    d = 1'b0;
    #1;
    chk("midrst_e_off",  32'(bus8.E_o),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation of the 2-bit counter, rise pulse right after reset release.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sat_cnt2", 32'(bus2.E_cnt_o), 32'(cnt_on ? 3 : 0));

    // Clear priority, then count up to 2 and clear again with E high.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_pre_cnt2", 32'(bus8.E_cnt_o), 32'(cnt_on ? 2 : 0));
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_cnt0", 32'(bus8.E_cnt_o), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("clr_then1", 32'(bus8.E_cnt_o), 32'(cnt_on ? 1 : 0));

    // Random toggling to exercise repeated rise pulses.
    for (int i = 0; i < 24; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
